// File: rtl/ram_2r1w_clr.sv
// Two-read/one-write byte-enabled RAM with a hardware zero-fill sequence (busy for DEPTH cycles).
// Read latency 1 cycle (2 with OUT_REG); no backpressure, one read per port per cycle, ports ignored while busy.
module ram_2r1w_clr #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int BYPASS  = 1,
    parameter int OUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic                  rd_en_1,
    input  logic                  rd_en_2,
    input  logic [ADDR_W-1:0]     rd_addr_1,
    input  logic [ADDR_W-1:0]     rd_addr_2,
    output logic [DATA_W-1:0]     rd_data_1,
    output logic [DATA_W-1:0]     rd_data_2,
    output logic                  rd_valid_1,
    output logic                  rd_valid_2,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NBE   = DATA_W / 8;

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;
    logic [NBE-1:0]      mem_be;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            S_CLEAR: begin
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (&clr_ptr_q) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clear_req) begin
                    state_d   = S_CLEAR;
                    clr_ptr_d = '0;
                end
            end
        endcase
    end

    assign busy = (state_q == S_CLEAR);

    // The clear sequence owns the write port completely while busy.
    always_comb begin
        mem_wa = wr_addr;
        mem_wd = wr_data;
        mem_be = wr_en ? wr_be : '0;
        if (busy) begin
            mem_wa = clr_ptr_q;
            mem_wd = '0;
            mem_be = '1;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NBE; b++) begin
            if (mem_be[b]) begin
                mem_q[mem_wa][8*b +: 8] <= mem_wd[8*b +: 8];
            end
        end
    end

    logic [1:0]          rd_en_v;
    logic [ADDR_W-1:0]   rd_addr_v  [2];
    logic [DATA_W-1:0]   rd_data_v  [2];
    logic [1:0]          rd_valid_v;

    assign rd_en_v      = {rd_en_2, rd_en_1};
    assign rd_addr_v[0] = rd_addr_1;
    assign rd_addr_v[1] = rd_addr_2;
    assign rd_data_1    = rd_data_v[0];
    assign rd_data_2    = rd_data_v[1];
    assign rd_valid_1   = rd_valid_v[0];
    assign rd_valid_2   = rd_valid_v[1];

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic                acc;
        logic [DATA_W-1:0]   fwd;
        logic                s1_vld_q;
        logic [DATA_W-1:0]   s1_dat_q;

        assign acc = rd_en_v[p] & ~busy;

        // Collision merge: enabled bytes come from the write in flight, the rest from the array.
        always_comb begin
            fwd = mem_q[rd_addr_v[p]];
            if (BYPASS != 0 && wr_en && wr_addr == rd_addr_v[p]) begin
                for (int b = 0; b < NBE; b++) begin
                    if (wr_be[b]) begin
                        fwd[8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_vld_q <= 1'b0;
                s1_dat_q <= '0;
            end else begin
                s1_vld_q <= acc;
                if (acc) begin
                    s1_dat_q <= fwd;
                end
            end
        end

        if (OUT_REG != 0) begin : g_oreg
            logic                s2_vld_q;
            logic [DATA_W-1:0]   s2_dat_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_vld_q <= 1'b0;
                    s2_dat_q <= '0;
                end else begin
                    s2_vld_q <= s1_vld_q;
                    if (s1_vld_q) begin
                        s2_dat_q <= s1_dat_q;
                    end
                end
            end

            assign rd_valid_v[p] = s2_vld_q;
            assign rd_data_v[p]  = s2_dat_q;
        end else begin : g_direct
            assign rd_valid_v[p] = s1_vld_q;
            assign rd_data_v[p]  = s1_dat_q;
        end
    end

endmodule

// File: tb/tb_ram_2r1w_clr.sv
// Bench for ram_2r1w_clr: default instance plus two 16-bit/16-deep instances (BYPASS=0+OUT_REG=1, BYPASS=1).
// Expected read results are queued at issue time; a negedge monitor checks arrival cycle, data and hold.
module tb_ram_2r1w_clr;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0, clr_a = 1'b0, clr_bc = 1'b0;

    logic        a_busy, a_rd_valid_1, a_rd_valid_2;
    logic        a_rd_en_1 = 1'b0, a_rd_en_2 = 1'b0, a_wr_en = 1'b0;
    logic [7:0]  a_rd_addr_1 = '0, a_rd_addr_2 = '0, a_wr_addr = '0, a_wr_data = '0;
    logic [7:0]  a_rd_data_1, a_rd_data_2;
    logic [0:0]  a_wr_be = '0;

    logic        bc_rd_en_1 = 1'b0, bc_rd_en_2 = 1'b0, bc_wr_en = 1'b0;
    logic [3:0]  bc_rd_addr_1 = '0, bc_rd_addr_2 = '0, bc_wr_addr = '0;
    logic [15:0] bc_wr_data = '0;
    logic [1:0]  bc_wr_be = '0;
    logic        b_busy, b_rd_valid_1, b_rd_valid_2, c_busy, c_rd_valid_1, c_rd_valid_2;
    logic [15:0] b_rd_data_1, b_rd_data_2, c_rd_data_1, c_rd_data_2;

    ram_2r1w_clr u_a (
        .clk(clk), .rst(rst), .clear_req(clr_a), .busy(a_busy),
        .rd_en_1(a_rd_en_1), .rd_en_2(a_rd_en_2), .rd_addr_1(a_rd_addr_1), .rd_addr_2(a_rd_addr_2),
        .rd_data_1(a_rd_data_1), .rd_data_2(a_rd_data_2), .rd_valid_1(a_rd_valid_1), .rd_valid_2(a_rd_valid_2),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be)
    );

    ram_2r1w_clr #(.ADDR_W(4), .DATA_W(16), .BYPASS(0), .OUT_REG(1)) u_b (
        .clk(clk), .rst(rst), .clear_req(clr_bc), .busy(b_busy),
        .rd_en_1(bc_rd_en_1), .rd_en_2(bc_rd_en_2), .rd_addr_1(bc_rd_addr_1), .rd_addr_2(bc_rd_addr_2),
        .rd_data_1(b_rd_data_1), .rd_data_2(b_rd_data_2), .rd_valid_1(b_rd_valid_1), .rd_valid_2(b_rd_valid_2),
        .wr_en(bc_wr_en), .wr_addr(bc_wr_addr), .wr_data(bc_wr_data), .wr_be(bc_wr_be)
    );

    ram_2r1w_clr #(.ADDR_W(4), .DATA_W(16), .BYPASS(1), .OUT_REG(0)) u_c (
        .clk(clk), .rst(rst), .clear_req(clr_bc), .busy(c_busy),
        .rd_en_1(bc_rd_en_1), .rd_en_2(bc_rd_en_2), .rd_addr_1(bc_rd_addr_1), .rd_addr_2(bc_rd_addr_2),
        .rd_data_1(c_rd_data_1), .rd_data_2(c_rd_data_2), .rd_valid_1(c_rd_valid_1), .rd_valid_2(c_rd_valid_2),
        .wr_en(bc_wr_en), .wr_addr(bc_wr_addr), .wr_data(bc_wr_data), .wr_be(bc_wr_be)
    );

    typedef struct {
        int          due;
        logic [15:0] dat;
    } exp_t;

    exp_t        exp_q [6][$];
    logic [15:0] last_d [6];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Port index: 0/1 = A port 1/2, 2/3 = B port 1/2, 4/5 = C port 1/2.
    task automatic mon(input int p, input logic v, input logic [15:0] d);
        logic due_now;
        exp_t e;
        if (rst) begin
            last_d[p] = '0;
            return;
        end
        while (exp_q[p].size() > 0 && exp_q[p][0].due < cyc) begin
            e = exp_q[p].pop_front();
            chk($sformatf("lost_read[%0d]", p), cyc, e.due);
        end
        due_now = (exp_q[p].size() > 0) && (exp_q[p][0].due == cyc);
        chk($sformatf("valid[%0d]", p), {31'b0, v}, {31'b0, due_now});
        if (due_now) begin
            e = exp_q[p].pop_front();
            if (v) chk($sformatf("data[%0d]", p), {16'b0, d}, {16'b0, e.dat});
        end
        if (!v) chk($sformatf("hold[%0d]", p), {16'b0, d}, {16'b0, last_d[p]});
        last_d[p] = d;
    endtask

    always @(negedge clk) begin
        mon(0, a_rd_valid_1, {8'h00, a_rd_data_1});
        mon(1, a_rd_valid_2, {8'h00, a_rd_data_2});
        mon(2, b_rd_valid_1, b_rd_data_1);
        mon(3, b_rd_valid_2, b_rd_data_2);
        mon(4, c_rd_valid_1, c_rd_data_1);
        mon(5, c_rd_valid_2, c_rd_data_2);
    end

    task automatic push(input int p, input int lat, input logic [15:0] d);
        exp_t e;
        e.due = cyc + lat;
        e.dat = d;
        exp_q[p].push_back(e);
    endtask

    task automatic a_rd(input int port, input logic [7:0] addr, input logic [7:0] expd);
        if (port == 1) begin
            a_rd_en_1 = 1'b1; a_rd_addr_1 = addr; push(0, 1, {8'h00, expd});
        end else begin
            a_rd_en_2 = 1'b1; a_rd_addr_2 = addr; push(1, 1, {8'h00, expd});
        end
    endtask

    task automatic a_wr(input logic [7:0] addr, input logic [7:0] dat, input logic [0:0] be);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = dat; a_wr_be = be;
    endtask

    task automatic bc_rd(input int port, input logic [3:0] addr, input logic [15:0] exp_b, input logic [15:0] exp_c);
        if (port == 1) begin
            bc_rd_en_1 = 1'b1; bc_rd_addr_1 = addr; push(2, 2, exp_b); push(4, 1, exp_c);
        end else begin
            bc_rd_en_2 = 1'b1; bc_rd_addr_2 = addr; push(3, 2, exp_b); push(5, 1, exp_c);
        end
    endtask

    task automatic bc_wr(input logic [3:0] addr, input logic [15:0] dat, input logic [1:0] be);
        bc_wr_en = 1'b1; bc_wr_addr = addr; bc_wr_data = dat; bc_wr_be = be;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        a_rd_en_1 = 1'b0; a_rd_en_2 = 1'b0; a_wr_en = 1'b0;
        bc_rd_en_1 = 1'b0; bc_rd_en_2 = 1'b0; bc_wr_en = 1'b0;
    endtask

    // Counts busy cycles per instance; optionally hammers the ports and holds clear_req while busy.
    task automatic run_clear(input int exp_a, input int exp_bc, input bit poke, input bit hold);
        int na, nb, nc, guard;
        na = 0; nb = 0; nc = 0; guard = 0;
        do begin
            @(negedge clk);
            if (a_busy) na++;
            if (b_busy) nb++;
            if (c_busy) nc++;
            guard++;
            a_rd_en_1 = poke && a_busy; a_rd_en_2 = poke && a_busy; a_wr_en = poke && a_busy;
            a_rd_addr_1 = 8'h05; a_rd_addr_2 = 8'h09; a_wr_addr = 8'h05; a_wr_data = 8'hEE; a_wr_be = 1'b1;
            bc_rd_en_1 = poke && b_busy; bc_rd_en_2 = poke && b_busy; bc_wr_en = poke && b_busy;
            bc_rd_addr_1 = 4'h5; bc_rd_addr_2 = 4'h9; bc_wr_addr = 4'h5; bc_wr_data = 16'hEEEE; bc_wr_be = 2'b11;
            clr_a = hold && a_busy;
            clr_bc = hold && b_busy;
        end while ((a_busy || b_busy || c_busy) && guard < 1000);
        chk("busy_cycles_a", na, exp_a);
        chk("busy_cycles_b", nb, exp_bc);
        chk("busy_cycles_c", nc, exp_bc);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] j;
        #1 rst = 1'b1;
        #1;
        chk("rst_busy_a", {31'b0, a_busy}, 1);
        chk("rst_busy_c", {31'b0, c_busy}, 1);
        chk("rst_valid_a1", {31'b0, a_rd_valid_1}, 0);
        chk("rst_data_a1", {24'b0, a_rd_data_1}, 0);
        chk("rst_data_b2", {16'b0, b_rd_data_2}, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        run_clear(256, 16, 1'b0, 1'b0);

        a_rd(1, 8'h10, 8'h00); a_rd(2, 8'h77, 8'h00);
        bc_rd(1, 4'h7, 16'h0000, 16'h0000); bc_rd(2, 4'hF, 16'h0000, 16'h0000);
        step();

        a_wr(8'h10, 8'hA5, 1'b1); step();
        a_rd(1, 8'h10, 8'hA5); a_rd(2, 8'h10, 8'hA5); step();

        a_wr(8'h20, 8'h5A, 1'b1); a_rd(1, 8'h20, 8'h5A); a_rd(2, 8'h20, 8'h5A); step();
        a_wr(8'h20, 8'hFF, 1'b0); a_rd(1, 8'h20, 8'h5A); step();
        a_rd(2, 8'h20, 8'h5A); step();

        bc_wr(4'h3, 16'h1234, 2'b11); step();
        bc_wr(4'h3, 16'hABCD, 2'b10);
        bc_rd(1, 4'h3, 16'h1234, 16'hAB34); bc_rd(2, 4'h3, 16'h1234, 16'hAB34); step();
        bc_rd(1, 4'h3, 16'hAB34, 16'hAB34); step();
        bc_wr(4'h3, 16'hFFFF, 2'b00); bc_rd(2, 4'h3, 16'hAB34, 16'hAB34); step();

        bc_wr(4'h1, 16'h1111, 2'b11); step();
        bc_wr(4'h2, 16'h2222, 2'b11); step();
        bc_wr(4'h3, 16'h3333, 2'b11); step();
        bc_wr(4'hF, 16'hF00F, 2'b11); step();
        bc_rd(2, 4'h1, 16'h1111, 16'h1111); step();
        bc_rd(2, 4'h2, 16'h2222, 16'h2222); step();
        bc_rd(2, 4'h3, 16'h3333, 16'h3333); step();
        bc_rd(1, 4'hF, 16'hF00F, 16'hF00F); bc_rd(2, 4'hF, 16'hF00F, 16'hF00F); step();
        repeat (3) step();

        for (int i = 0; i < 256; i++) begin
            j = 8'(i);
            a_wr(j, j ^ 8'h5A, 1'b1);
            step();
        end
        a_rd(1, 8'h00, 8'h5A); a_rd(2, 8'hFF, 8'hA5); step();
        a_rd(1, 8'h80, 8'hDA); a_rd(2, 8'h80, 8'hDA); step();

        clr_a = 1'b1;
        step();
        run_clear(256, 0, 1'b1, 1'b1);
        chk("no_restart_busy_a", {31'b0, a_busy}, 0);
        for (int i = 0; i < 256; i++) begin
            j = 8'(i);
            a_rd(1, j, 8'h00);
            a_rd(2, ~j, 8'h00);
            step();
        end

        a_wr(8'h10, 8'hA5, 1'b1); step();
        a_rd(1, 8'h10, 8'hA5); bc_rd(2, 4'h1, 16'h1111, 16'h1111); step();
        repeat (3) step();
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        chk("midclear_busy_a", {31'b0, a_busy}, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_data_a1", {24'b0, a_rd_data_1}, 0);
        chk("async_rst_data_b2", {16'b0, b_rd_data_2}, 0);
        chk("async_rst_data_c2", {16'b0, c_rd_data_2}, 0);
        chk("async_rst_busy_b", {31'b0, b_busy}, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        run_clear(256, 16, 1'b0, 1'b0);
        a_rd(1, 8'h10, 8'h00); a_rd(2, 8'h64, 8'h00); bc_rd(2, 4'h1, 16'h0000, 16'h0000); step();
        repeat (4) step();

        for (int p = 0; p < 6; p++) begin
            chk($sformatf("drain[%0d]", p), exp_q[p].size(), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
